dfa_stream_ctx_engine: RTL and testbench
========================================

// Module: dfa_stream_ctx_engine
// PURPOSE
// Generic per-stream context wrapper around one registered regex DFA in the DPI datapath.
// - Saves and restores DFA state per stream ID across packets.
// - Keeps saturating per-stream and total match counters.
// - Sweeps all contexts clear on command.
// - Replaces the fixed 11-bit/64-stream per-category wrappers; the DFA attaches through dfa_* ports.
// PARAMETERS
// STATE_W   11  DFA state width
// SID_W     6   stream ID width; NSTREAM = 2**SID_W contexts
// COUNT_W   16  width of all match counters (saturating)
// PORTS
// clk            in   1        clock
// rst_n          in   1        reset, synchronous, active-low
// sop            in   1        packet start; samples stream_id, new_stream, enable
// stream_id      in   SID_W    stream of the packet; valid on sop
// new_stream     in   1        on sop: discard saved state, start DFA at state 0
// enable         in   1        on sop: regex enabled for this packet
// char_in        in   8        payload byte
// char_vld       in   1        char_in valid; honoured only in RUN
// eop            in   1        packet end; at least 1 cycle after the last char_vld
// clear_all      in   1        pulse: invalidate all contexts and zero all counters
// busy           out  1        high in LOAD, DRAIN, COMMIT, CLEAR; sop/clear_all ignored while high
// proto_err      out  1        sticky; set by any ignored sop/eop/clear_all or char_vld outside RUN; cleared by reset
// fired          out  1        match seen in current/last enabled packet
// total_count    out  COUNT_W  packets with a match, all streams
// cnt_rd_id      in   SID_W    per-stream count read address
// cnt_rd_data    out  COUNT_W  count for cnt_rd_id, 1-cycle read latency
// dfa_char       out  8        registered char to DFA
// dfa_char_vld   out  1        registered char valid to DFA
// dfa_state      out  STATE_W  registered state load value to DFA
// dfa_state_vld  out  1        registered state load strobe to DFA
// dfa_state_out  in   STATE_W  DFA current state
// dfa_accept     in   1        DFA accept; registered here before use
// BEHAVIOUR
// - Reset: FSM=IDLE; busy, fired, proto_err, dfa_char_vld, dfa_state_vld = 0; total_count = 0.
//   All ctx_valid bits, all per-stream counts, cnt_rd_data = 0. State RAM contents don't-care.
// - FSM states: IDLE, LOAD, RUN, DRAIN, COMMIT, CLEAR.
// - IDLE: sop -> LOAD. clear_all -> CLEAR. clear_all wins if both assert; the sop is ignored and sets proto_err.
// - LOAD (1 cycle): fired<=0.
//   - State select: 0 if new_stream or !ctx_valid[sid], else state_ram[sid].
//   - dfa_state_vld pulses the cycle after LOAD; then -> RUN.
// - RUN:
//   - If enable: char_vld registered to dfa_char/_vld (1 cycle).
//   - If !enable: dfa_char_vld held 0.
//   - eop -> DRAIN.
// - Accept path: dfa_accept registered (accept_r); fired<=1 when accept_r && enable. fired is cleared only at next LOAD.
//   Char at cycle t can set fired at t+3 earliest.
// - DRAIN: 3 cycles, so the last char's state/accept settle; -> COMMIT.
// - COMMIT (1 cycle):
//   - If enable: state_ram[sid] <= registered state_out; ctx_valid[sid] <= 1.
//   - If fired: stream count[sid] and total_count each +1, saturating at all-ones.
//   - If !enable: no writes.
//   - -> IDLE.
// - CLEAR: 2**SID_W cycles, index 0..NSTREAM-1.
//   - Each cycle zeroes ctx_valid[i] and count[i].
//   - total_count and fired zeroed on entry.
//   - -> IDLE after last index.
// - cnt_rd_data reads at any time. A COMMIT write to the same sid is visible the cycle after COMMIT.
// - Mid-packet rst_n low: packet abandoned, nothing committed, all of the above reset values apply.
// TESTING
// - Reset, then sop sid=5 new=1 en=1, bytes matching regex, eop -> fired=1, total=1, cnt[5]=1, busy low 5 cycles after eop.
// - Pattern split across two packets on sid=3 (new=1 then new=0) -> match only in pkt 2; cnt[3]=1.
//   Same split with sid=4 between -> cnt[4]=0.
// - en=0 packet containing match on sid=7 -> fired=0, counts unchanged, sid 7 state unchanged.
// - Preload cnt[2] and total to 16'hFFFE; 3 matching packets -> both saturate at 16'hFFFF.
// - clear_all after traffic on sid 1,9 -> busy 64 cycles, cnt[1]=cnt[9]=0, total=0; next new=0 packet starts at state 0.
// - sop during DRAIN and char_vld in IDLE -> ignored, proto_err=1; rst_n low mid-RUN -> no commit, outputs reset.

Source files
------------

// File: rtl/dfa_stream_ctx_engine.sv
// Per-stream context wrapper around one registered regex DFA: saves/restores DFA state
// per stream ID, keeps saturating per-stream and total match counters, sweeps contexts clear.
module dfa_stream_ctx_engine #(
    parameter int STATE_W = 11,
    parameter int SID_W   = 6,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sop,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream,
    input  logic               enable,
    input  logic [7:0]         char_in,
    input  logic               char_vld,
    input  logic               eop,
    input  logic               clear_all,
    output logic               busy,
    output logic               proto_err,
    output logic               fired,
    output logic [COUNT_W-1:0] total_count,
    input  logic [SID_W-1:0]   cnt_rd_id,
    output logic [COUNT_W-1:0] cnt_rd_data,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state,
    output logic               dfa_state_vld,
    input  logic [STATE_W-1:0] dfa_state_out,
    input  logic               dfa_accept
);

    localparam int NSTREAM = 1 << SID_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_COMMIT = 3'd4,
        S_CLEAR  = 3'd5
    } st_e;

    st_e                 state_q, state_d;
    logic [SID_W-1:0]    sid_q, sid_d;
    logic                new_q, new_d;
    logic                en_q, en_d;
    logic [1:0]          drain_cnt_q, drain_cnt_d;
    logic [SID_W-1:0]    clr_idx_q, clr_idx_d;
    logic                busy_q, busy_d;
    logic                perr_q, perr_d;
    logic                fired_q, fired_d;
    logic [COUNT_W-1:0]  total_q, total_d;
    logic [COUNT_W-1:0]  cnt_rd_q, cnt_rd_d;
    logic [7:0]          dfa_char_q, dfa_char_d;
    logic                dfa_char_vld_q, dfa_char_vld_d;
    logic [STATE_W-1:0]  dfa_state_q, dfa_state_d;
    logic                dfa_state_vld_q, dfa_state_vld_d;
    logic                accept_q, accept_d;
    logic [STATE_W-1:0]  state_out_q, state_out_d;
    logic [1:0]          arm_q, arm_d;
    logic [NSTREAM-1:0]  ctx_valid_q, ctx_valid_d;
    logic [COUNT_W-1:0]  cnt_q [NSTREAM];
    logic [COUNT_W-1:0]  cnt_d [NSTREAM];
    logic [STATE_W-1:0]  state_ram_q [NSTREAM];
    logic [STATE_W-1:0]  state_ram_d [NSTREAM];
    logic                perr_set_s;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state, context update and output computation
    always_comb begin
        state_d         = state_q;
        sid_d           = sid_q;
        new_d           = new_q;
        en_d            = en_q;
        drain_cnt_d     = drain_cnt_q;
        clr_idx_d       = clr_idx_q;
        fired_d         = fired_q;
        total_d         = total_q;
        dfa_char_d      = dfa_char_q;
        dfa_char_vld_d  = 1'b0;
        dfa_state_d     = dfa_state_q;
        dfa_state_vld_d = 1'b0;
        accept_d        = dfa_accept;
        state_out_d     = dfa_state_out;
        ctx_valid_d     = ctx_valid_q;
        cnt_d           = cnt_q;
        state_ram_d     = state_ram_q;

        perr_set_s = 1'b0;
        if (char_vld && (state_q != S_RUN)) begin
            perr_set_s = 1'b1;
        end
        if (eop && (state_q != S_RUN)) begin
            perr_set_s = 1'b1;
        end
        if (sop && ((state_q != S_IDLE) || clear_all)) begin
            perr_set_s = 1'b1;
        end
        if (clear_all && (state_q != S_IDLE)) begin
            perr_set_s = 1'b1;
        end
        perr_d = perr_q | perr_set_s;

        // Accept is trusted only once the loaded state has propagated through DFA and accept_q
        arm_d = {arm_q[1] | arm_q[0], arm_q[0] | dfa_state_vld_q};
        if (((state_q == S_RUN) || (state_q == S_DRAIN)) && arm_q[1] && accept_q && en_q) begin
            fired_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (clear_all) begin
                    state_d   = S_CLEAR;
                    total_d   = '0;
                    fired_d   = 1'b0;
                    clr_idx_d = '0;
                end else if (sop) begin
                    state_d = S_LOAD;
                    sid_d   = stream_id;
                    new_d   = new_stream;
                    en_d    = enable;
                end
            end
            S_LOAD: begin
                fired_d         = 1'b0;
                arm_d           = 2'b00;
                dfa_state_vld_d = 1'b1;
                if (new_q || !ctx_valid_q[sid_q]) begin
                    dfa_state_d = '0;
                end else begin
                    dfa_state_d = state_ram_q[sid_q];
                end
                state_d = S_RUN;
            end
            S_RUN: begin
                if (char_vld && en_q) begin
                    dfa_char_d     = char_in;
                    dfa_char_vld_d = 1'b1;
                end
                if (eop) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 2'd0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == 2'd2) begin
                    state_d = S_COMMIT;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            S_COMMIT: begin
                if (en_q) begin
                    state_ram_d[sid_q] = state_out_q;
                    ctx_valid_d[sid_q] = 1'b1;
                end
                if (fired_q) begin
                    cnt_d[sid_q] = sat_inc(cnt_q[sid_q]);
                    total_d      = sat_inc(total_q);
                end
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                ctx_valid_d[clr_idx_q] = 1'b0;
                cnt_d[clr_idx_q]       = '0;
                if (&clr_idx_q) begin
                    state_d = S_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + {{(SID_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reading the post-update array makes a same-cycle COMMIT/CLEAR write visible next cycle
        cnt_rd_d = cnt_d[cnt_rd_id];
        busy_d   = (state_d == S_LOAD) || (state_d == S_DRAIN) ||
                   (state_d == S_COMMIT) || (state_d == S_CLEAR);
    end

    // Control, counter and DFA interface registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            sid_q           <= '0;
            new_q           <= 1'b0;
            en_q            <= 1'b0;
            drain_cnt_q     <= 2'd0;
            clr_idx_q       <= '0;
            busy_q          <= 1'b0;
            perr_q          <= 1'b0;
            fired_q         <= 1'b0;
            total_q         <= '0;
            cnt_rd_q        <= '0;
            dfa_char_q      <= 8'd0;
            dfa_char_vld_q  <= 1'b0;
            dfa_state_q     <= '0;
            dfa_state_vld_q <= 1'b0;
            accept_q        <= 1'b0;
            state_out_q     <= '0;
            arm_q           <= 2'b00;
            ctx_valid_q     <= '0;
            cnt_q           <= '{default: '0};
        end else begin
            state_q         <= state_d;
            sid_q           <= sid_d;
            new_q           <= new_d;
            en_q            <= en_d;
            drain_cnt_q     <= drain_cnt_d;
            clr_idx_q       <= clr_idx_d;
            busy_q          <= busy_d;
            perr_q          <= perr_d;
            fired_q         <= fired_d;
            total_q         <= total_d;
            cnt_rd_q        <= cnt_rd_d;
            dfa_char_q      <= dfa_char_d;
            dfa_char_vld_q  <= dfa_char_vld_d;
            dfa_state_q     <= dfa_state_d;
            dfa_state_vld_q <= dfa_state_vld_d;
            accept_q        <= accept_d;
            state_out_q     <= state_out_d;
            arm_q           <= arm_d;
            ctx_valid_q     <= ctx_valid_d;
            cnt_q           <= cnt_d;
        end
    end

    // Saved DFA states; contents are meaningless until the matching ctx_valid bit is set
    always_ff @(posedge clk) begin
        state_ram_q <= state_ram_d;
    end

    assign busy          = busy_q;
    assign proto_err     = perr_q;
    assign fired         = fired_q;
    assign total_count   = total_q;
    assign cnt_rd_data   = cnt_rd_q;
    assign dfa_char      = dfa_char_q;
    assign dfa_char_vld  = dfa_char_vld_q;
    assign dfa_state     = dfa_state_q;
    assign dfa_state_vld = dfa_state_vld_q;

endmodule

// File: tb/tb_dfa_stream_ctx_engine.sv
// Scoreboard bench for dfa_stream_ctx_engine with an "abc"-substring DFA model attached;
// a second narrow-counter instance exercises counter saturation.
module tb_dfa_stream_ctx_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sat_en = 1'b0;
    logic        rst_sat_n;
    logic        sop = 1'b0, new_stream = 1'b0, enable = 1'b0;
    logic        char_vld = 1'b0, eop = 1'b0, clear_all = 1'b0;
    logic [5:0]  stream_id = 6'd0, cnt_rd_id = 6'd0;
    logic [7:0]  char_in = 8'd0;
    logic        snap = 1'b0;

    logic        busy, proto_err, fired, dfa_char_vld, dfa_state_vld, dfa_accept;
    logic [15:0] total_count, cnt_rd_data;
    logic [7:0]  dfa_char;
    logic [10:0] dfa_state, dfa_state_out;
    logic [10:0] m_st = 11'd0;

    logic        s_busy, s_perr, s_fired, s_char_vld, s_state_vld, s_accept;
    logic [1:0]  s_total, s_cnt;
    logic [7:0]  s_char;
    logic [10:0] s_state, s_state_out;
    logic [10:0] s_m_st = 11'd0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int eop_cyc = 0;
    int run_len = 0;
    int last_load = -1;
    logic busy_prev = 1'b0;

    typedef struct {
        string       name;
        logic        fired;
        logic [15:0] total;
        logic [15:0] cnt;
        logic        perr;
        int          lat;
        int          blen;
        int          load;
        logic        chk_sat;
        logic [1:0]  s_total;
        logic [1:0]  s_cnt;
    } exp_t;
    exp_t sb_q[$];

    assign rst_sat_n = rst_n & sat_en;

    dfa_stream_ctx_engine #(.STATE_W(11), .SID_W(6), .COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .sop(sop), .stream_id(stream_id), .new_stream(new_stream),
        .enable(enable), .char_in(char_in), .char_vld(char_vld), .eop(eop), .clear_all(clear_all),
        .busy(busy), .proto_err(proto_err), .fired(fired), .total_count(total_count),
        .cnt_rd_id(cnt_rd_id), .cnt_rd_data(cnt_rd_data), .dfa_char(dfa_char),
        .dfa_char_vld(dfa_char_vld), .dfa_state(dfa_state), .dfa_state_vld(dfa_state_vld),
        .dfa_state_out(dfa_state_out), .dfa_accept(dfa_accept)
    );

    dfa_stream_ctx_engine #(.STATE_W(11), .SID_W(6), .COUNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_sat_n), .sop(sop), .stream_id(stream_id), .new_stream(new_stream),
        .enable(enable), .char_in(char_in), .char_vld(char_vld), .eop(eop), .clear_all(clear_all),
        .busy(s_busy), .proto_err(s_perr), .fired(s_fired), .total_count(s_total),
        .cnt_rd_id(cnt_rd_id), .cnt_rd_data(s_cnt), .dfa_char(s_char),
        .dfa_char_vld(s_char_vld), .dfa_state(s_state), .dfa_state_vld(s_state_vld),
        .dfa_state_out(s_state_out), .dfa_accept(s_accept)
    );

    always #5 clk = ~clk;

    // Reference DFA: accepts on completing the substring "abc"
    function automatic logic [10:0] dfa_next(input logic [10:0] s, input logic [7:0] c);
        if (c == 8'h61) return 11'd1;
        case (s)
            11'd1:   return (c == 8'h62) ? 11'd2 : 11'd0;
            11'd2:   return (c == 8'h63) ? 11'd3 : 11'd0;
            default: return 11'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (dfa_state_vld) m_st <= dfa_state;
        else if (dfa_char_vld) m_st <= dfa_next(m_st, dfa_char);
    end
    always_ff @(posedge clk) begin
        if (s_state_vld) s_m_st <= s_state;
        else if (s_char_vld) s_m_st <= dfa_next(s_m_st, s_char);
    end
    assign dfa_state_out = m_st;
    assign dfa_accept    = (m_st == 11'd3);
    assign s_state_out   = s_m_st;
    assign s_accept      = (s_m_st == 11'd3);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: a packet/clear completes when busy drops outside the load handshake
    always @(negedge clk) begin : monitor
        exp_t e;
        logic trig;
        if (eop) eop_cyc = cyc;
        if (dfa_state_vld) last_load = int'(dfa_state);
        trig = snap || (busy_prev && !busy && !dfa_state_vld);
        if (trig) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_completion: got output at cycle %0d expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, ".busy"}, {31'd0, busy}, 32'd0);
                chk({e.name, ".fired"}, {31'd0, fired}, {31'd0, e.fired});
                chk({e.name, ".total"}, {16'd0, total_count}, {16'd0, e.total});
                chk({e.name, ".cnt"}, {16'd0, cnt_rd_data}, {16'd0, e.cnt});
                chk({e.name, ".proto_err"}, {31'd0, proto_err}, {31'd0, e.perr});
                if (e.lat != 0) chk({e.name, ".eop_to_idle"}, cyc - eop_cyc, e.lat);
                if (e.blen != 0) chk({e.name, ".busy_len"}, run_len, e.blen);
                if (e.load >= 0) chk({e.name, ".load_state"}, last_load, e.load);
                if (e.chk_sat) begin
                    chk({e.name, ".sat_total"}, {30'd0, s_total}, {30'd0, e.s_total});
                    chk({e.name, ".sat_cnt"}, {30'd0, s_cnt}, {30'd0, e.s_cnt});
                end
            end
        end
        if (busy) run_len++;
        else run_len = 0;
        busy_prev = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic f, input logic [15:0] tot, input logic [15:0] cnt,
                        input logic pe, input int lat, input int blen, input int load,
                        input logic cs, input logic [1:0] st, input logic [1:0] sc);
        exp_t e;
        e.name = nm; e.fired = f; e.total = tot; e.cnt = cnt; e.perr = pe;
        e.lat = lat; e.blen = blen; e.load = load; e.chk_sat = cs; e.s_total = st; e.s_cnt = sc;
        sb_q.push_back(e);
    endtask

    task automatic send_pkt(input logic [5:0] sid, input logic nw, input logic en, input string s,
                            input logic [5:0] rd, input logic sop_in_drain);
        cnt_rd_id = rd;
        stream_id = sid; new_stream = nw; enable = en; sop = 1'b1;
        tick();
        sop = 1'b0;
        tick();
        for (int i = 0; i < s.len(); i++) begin
            char_in = s[i];
            char_vld = 1'b1;
            tick();
        end
        char_vld = 1'b0;
        tick();
        eop = 1'b1;
        tick();
        eop = 1'b0;
        if (sop_in_drain) begin
            stream_id = 6'd11; new_stream = 1'b1; sop = 1'b1;
            tick();
            sop = 1'b0;
        end
        repeat (6) tick();
    endtask

    task automatic pulse_snap();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        cnt_rd_id = 6'd0;
        push("reset", 1'b0, 16'd0, 16'd0, 1'b0, 0, 0, -1, 1'b0, 2'd0, 2'd0);
        pulse_snap();

        push("p1_sid5", 1'b1, 16'd1, 16'd1, 1'b0, 5, 4, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd5, 1'b1, 1'b1, "abc", 6'd5, 1'b0);
        push("p2_sid3a", 1'b0, 16'd1, 16'd0, 1'b0, 0, 4, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd3, 1'b1, 1'b1, "xab", 6'd3, 1'b0);
        push("p3_sid3b", 1'b1, 16'd2, 16'd1, 1'b0, 0, 0, 2, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd3, 1'b0, 1'b1, "cx", 6'd3, 1'b0);
        push("p4_sid8a", 1'b0, 16'd2, 16'd0, 1'b0, 0, 0, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd8, 1'b1, 1'b1, "xab", 6'd8, 1'b0);
        push("p5_sid4", 1'b0, 16'd2, 16'd0, 1'b0, 0, 0, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd4, 1'b1, 1'b1, "zz", 6'd4, 1'b0);
        push("p6_sid8b", 1'b1, 16'd3, 16'd0, 1'b0, 0, 0, 2, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd8, 1'b0, 1'b1, "cx", 6'd4, 1'b0);
        push("p7_sid7", 1'b0, 16'd3, 16'd0, 1'b0, 0, 0, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd7, 1'b1, 1'b1, "ab", 6'd7, 1'b0);
        push("p8_sid7_dis", 1'b0, 16'd3, 16'd0, 1'b0, 0, 0, 2, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd7, 1'b0, 1'b0, "abc", 6'd7, 1'b0);
        push("p9_sid7", 1'b1, 16'd4, 16'd1, 1'b0, 0, 0, 2, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd7, 1'b0, 1'b1, "c", 6'd7, 1'b0);
        push("p10_sid1", 1'b1, 16'd5, 16'd1, 1'b0, 0, 0, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd1, 1'b1, 1'b1, "abc", 6'd1, 1'b0);
        push("p11_sid9", 1'b1, 16'd6, 16'd1, 1'b0, 0, 0, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd9, 1'b1, 1'b1, "abcab", 6'd9, 1'b0);

        cnt_rd_id = 6'd9;
        push("clear", 1'b0, 16'd0, 16'd0, 1'b0, 0, 64, -1, 1'b0, 2'd0, 2'd0);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        repeat (70) tick();
        push("p12_sid9_after_clr", 1'b0, 16'd0, 16'd0, 1'b0, 0, 0, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd9, 1'b0, 1'b1, "c", 6'd9, 1'b0);
        push("p13_sid1_after_clr", 1'b0, 16'd0, 16'd0, 1'b0, 0, 0, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd1, 1'b0, 1'b1, "x", 6'd1, 1'b0);

        sat_en = 1'b1;
        repeat (2) tick();
        push("sat1", 1'b1, 16'd1, 16'd1, 1'b0, 0, 0, 0, 1'b1, 2'd1, 2'd1);
        send_pkt(6'd2, 1'b1, 1'b1, "abc", 6'd2, 1'b0);
        push("sat2", 1'b1, 16'd2, 16'd2, 1'b0, 0, 0, 0, 1'b1, 2'd2, 2'd2);
        send_pkt(6'd2, 1'b1, 1'b1, "abc", 6'd2, 1'b0);
        push("sat3", 1'b1, 16'd3, 16'd3, 1'b0, 0, 0, 0, 1'b1, 2'd3, 2'd3);
        send_pkt(6'd2, 1'b1, 1'b1, "abc", 6'd2, 1'b0);
        push("sat4", 1'b1, 16'd4, 16'd4, 1'b0, 0, 0, 0, 1'b1, 2'd3, 2'd3);
        send_pkt(6'd2, 1'b1, 1'b1, "abc", 6'd2, 1'b0);
        push("sat5", 1'b1, 16'd5, 16'd5, 1'b0, 0, 0, 0, 1'b1, 2'd3, 2'd3);
        send_pkt(6'd2, 1'b1, 1'b1, "abc", 6'd2, 1'b0);

        push("sop_in_drain", 1'b1, 16'd6, 16'd1, 1'b1, 0, 4, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd10, 1'b1, 1'b1, "abc", 6'd10, 1'b1);
        push("p_sid11", 1'b0, 16'd6, 16'd0, 1'b1, 0, 0, 0, 1'b0, 2'd0, 2'd0);
        send_pkt(6'd11, 1'b0, 1'b1, "c", 6'd11, 1'b0);

        cnt_rd_id = 6'd12;
        stream_id = 6'd12; new_stream = 1'b1; enable = 1'b1; sop = 1'b1;
        tick();
        sop = 1'b0;
        tick();
        char_in = 8'h61; char_vld = 1'b1;
        tick();
        char_in = 8'h62;
        tick();
        char_vld = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push("reset_mid_run", 1'b0, 16'd0, 16'd0, 1'b0, 0, 0, -1, 1'b0, 2'd0, 2'd0);
        pulse_snap();

        push("char_in_idle", 1'b0, 16'd0, 16'd0, 1'b1, 0, 0, -1, 1'b0, 2'd0, 2'd0);
        char_vld = 1'b1;
        tick();
        char_vld = 1'b0;
        tick();
        pulse_snap();

        repeat (5) tick();
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
